// File: rtl/bpm_uart_report.sv
// bpm_uart_report
//   Turns each BPM sample into one ASCII report line on UART_tx: three
//   zero-padded decimal digits followed by CR LF (or LF only). A depth-1
//   pending buffer catches samples that arrive while a line is in flight.
//   Newer samples overwrite the buffered one and raise a sticky overrun.
//
// Optional feature (compile-time macro BPM_HDR_EN):
//   When defined, every line is prefixed with "BPM=". The decimal
//   conversion then runs in the background while the header goes out.
//
// Parameters
//   EOL_CRLF    1: line ends CR LF, 0: LF only
//   GAP_CYCLES  idle cycles appended after each line (0..255)
//
// Ports
//   clk, rst_n   clock (rising edge) / asynchronous active-low reset
//   bpm_valid    one-cycle strobe qualifying bpm_value
//   bpm_value    sample 0..255
//   clr_overrun  one-cycle strobe clearing overrun (a simultaneous set wins)
//   uart_busy    UART_tx busy
//   uart_start   UART_tx tx_start, one-cycle pulse
//   uart_data    UART_tx data_in, stable from the pulse until busy falls
//   report_busy  high from sample acceptance to the end of line and gap
//   overrun      sticky: a pending sample was overwritten
module bpm_uart_report #(
  parameter bit EOL_CRLF   = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bpm_valid,
  input  logic [7:0] bpm_value,
  input  logic       clr_overrun,
  input  logic       uart_busy,
  output logic       uart_start,
  output logic [7:0] uart_data,
  output logic       report_busy,
  output logic       overrun
);

`ifdef BPM_HDR_EN
  localparam int HDR_LEN = 4;
`else
  localparam int HDR_LEN = 0;
`endif
  localparam int LINE_LEN = HDR_LEN + 3 + (EOL_CRLF ? 2 : 1);
  localparam int IDX_W    = $clog2(LINE_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);
  localparam logic [7:0]       GAP_INIT = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_START, S_WAIT_HI, S_WAIT_LO, S_GAP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       gap_cnt;

  // conversion datapath
  logic [7:0] work;
  logic [1:0] hund;
  logic [3:0] tens;
  logic       conv_act;

  // pending buffer
  logic       pend_full;
  logic [7:0] pend_val;

  logic             load;
  logic [7:0]       load_val;
  logic             conv_leave;
  logic             cur_ready, nxt_ready;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       cur_char, nxt_char;
  logic             ov_set;

  // Character at line position i, given the decimal digits.
  function automatic logic [7:0] line_char(input logic [IDX_W-1:0] i,
                                           input logic [1:0] h,
                                           input logic [3:0] t,
                                           input logic [3:0] o);
    int k;
    k = int'(i);
    line_char = 8'h0A;
`ifdef BPM_HDR_EN
    if      (k == 0) line_char = 8'h42;
    else if (k == 1) line_char = 8'h50;
    else if (k == 2) line_char = 8'h4D;
    else if (k == 3) line_char = 8'h3D;
    else
`endif
    if      (k == HDR_LEN)                 line_char = {6'b001100, h};
    else if (k == HDR_LEN + 1)             line_char = {4'h3, t};
    else if (k == HDR_LEN + 2)             line_char = {4'h3, o};
    else if (EOL_CRLF && k == HDR_LEN + 3) line_char = 8'h0D;
  endfunction

  // Pending sample has priority over a new strobe in IDLE.
  assign load     = (state == S_IDLE) && (pend_full || bpm_valid);
  assign load_val = pend_full ? pend_val : bpm_value;
  assign ov_set   = bpm_valid && (state != S_IDLE) && pend_full;

  assign idx_nxt  = idx + 1'b1;
  assign cur_char = line_char(idx,     hund, tens, work[3:0]);
  assign nxt_char = line_char(idx_nxt, hund, tens, work[3:0]);

`ifdef BPM_HDR_EN
  // Header chars need no digits; digits wait for the background conversion.
  assign conv_leave = 1'b1;
  assign cur_ready  = !conv_act || (idx     < IDX_W'(HDR_LEN));
  assign nxt_ready  = !conv_act || (idx_nxt < IDX_W'(HDR_LEN));
`else
  // The last CONV cycle is the one that finds the remainder below 10.
  assign conv_leave = conv_act && (work < 8'd10);
  assign cur_ready  = 1'b1;
  assign nxt_ready  = 1'b1;
`endif

  // Repeated subtraction: hundreds first, then tens; remainder is ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      hund     <= '0;
      tens     <= '0;
      conv_act <= 1'b0;
    end else if (load) begin
      work     <= load_val;
      hund     <= '0;
      tens     <= '0;
      conv_act <= 1'b1;
    end else if (conv_act) begin
      if (work >= 8'd100) begin
        work <= work - 8'd100;
        hund <= hund + 2'd1;
      end else if (work >= 8'd10) begin
        work <= work - 8'd10;
        tens <= tens + 4'd1;
      end else begin
        conv_act <= 1'b0;
      end
    end
  end

  // Pending buffer and sticky overrun. A strobe that coincides with IDLE
  // serving the buffer refills it, so no sample is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_val  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (state != S_IDLE) begin
        if (bpm_valid) begin
          pend_full <= 1'b1;
          pend_val  <= bpm_value;
        end
      end else if (pend_full) begin
        pend_full <= bpm_valid;
        if (bpm_valid) pend_val <= bpm_value;
      end
      if (ov_set)           overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  // Line sequencer. uart_start is raised on entry to START when the UART is
  // idle and the char is ready; otherwise START raises it once both hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      uart_start  <= 1'b0;
      uart_data   <= '0;
      report_busy <= 1'b0;
    end else begin
      uart_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            state       <= S_CONV;
            idx         <= '0;
            report_busy <= 1'b1;
          end
        end
        S_CONV: begin
          if (conv_leave) begin
            state <= S_START;
            if (!uart_busy && cur_ready) begin
              uart_start <= 1'b1;
              uart_data  <= cur_char;
            end
          end
        end
        S_START: begin
          if (uart_start) begin
            state <= S_WAIT_HI;
          end else if (!uart_busy && cur_ready) begin
            uart_start <= 1'b1;
            uart_data  <= cur_char;
          end
        end
        S_WAIT_HI: begin
          if (uart_busy) state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!uart_busy) begin
            if (idx == LAST_IDX) begin
              if (GAP_CYCLES == 0) begin
                state       <= S_IDLE;
                report_busy <= 1'b0;
              end else begin
                state   <= S_GAP;
                gap_cnt <= GAP_INIT;
              end
            end else begin
              idx   <= idx_nxt;
              state <= S_START;
              if (nxt_ready) begin
                uart_start <= 1'b1;
                uart_data  <= nxt_char;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            state       <= S_IDLE;
            report_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state       <= S_IDLE;
          report_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpm_uart_report.sv
// Directed bench for bpm_uart_report. Three instances share clk/rst_n:
//   0: defaults (CR LF, no gap), 1: EOL_CRLF=0, 2: GAP_CYCLES=4.
// Each has a simple UART_tx model that captures the byte on uart_start and
// holds busy for BYTE_CYC cycles.
module tb_bpm_uart_report;

  localparam int BYTE_CYC = 6;
  localparam int BUF_N    = 128;
  localparam int LIM      = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] bv = '0;
  logic [7:0] bval [3] = '{8'd0, 8'd0, 8'd0};
  logic [2:0] clr = '0;
  logic [2:0] ubusy = '0;
  logic [2:0] ustart;
  logic [7:0] udata [3];
  logic [2:0] rb;
  logic [2:0] ov;

  logic [7:0] rx_buf [3][BUF_N];
  int         rx_n [3] = '{0, 0, 0};
  int         ucnt [3] = '{0, 0, 0};

  int checks = 0;
  int errors = 0;

`ifdef BPM_HDR_EN
  string hdr = "BPM=";
`else
  string hdr = "";
`endif

  always #5 clk = ~clk;

  bpm_uart_report dut0 (
    .clk(clk), .rst_n(rst_n), .bpm_valid(bv[0]), .bpm_value(bval[0]),
    .clr_overrun(clr[0]), .uart_busy(ubusy[0]), .uart_start(ustart[0]),
    .uart_data(udata[0]), .report_busy(rb[0]), .overrun(ov[0]));

  bpm_uart_report #(.EOL_CRLF(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bpm_valid(bv[1]), .bpm_value(bval[1]),
    .clr_overrun(clr[1]), .uart_busy(ubusy[1]), .uart_start(ustart[1]),
    .uart_data(udata[1]), .report_busy(rb[1]), .overrun(ov[1]));

  bpm_uart_report #(.GAP_CYCLES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bpm_valid(bv[2]), .bpm_value(bval[2]),
    .clr_overrun(clr[2]), .uart_busy(ubusy[2]), .uart_start(ustart[2]),
    .uart_data(udata[2]), .report_busy(rb[2]), .overrun(ov[2]));

  // UART_tx models + byte collectors
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ustart[i]) begin
        if (rx_n[i] < BUF_N) rx_buf[i][rx_n[i]] <= udata[i];
        rx_n[i]  <= rx_n[i] + 1;
        ubusy[i] <= 1'b1;
        ucnt[i]  <= BYTE_CYC;
      end else if (ubusy[i]) begin
        if (ucnt[i] <= 1) ubusy[i] <= 1'b0;
        else              ucnt[i]  <= ucnt[i] - 1;
      end
    end
  end

  task automatic send(input int i, input logic [7:0] v);
    @(negedge clk);
    bv[i]   = 1'b1;
    bval[i] = v;
    @(negedge clk);
    bv[i]   = 1'b0;
  endtask

  task automatic wait_bytes(input int i, input int target);
    int n = 0;
    while (rx_n[i] < target && n < LIM) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_n[i] < target) begin
      errors++;
      $display("FAIL wait_bytes[%0d] got %0d bytes want %0d", i, rx_n[i], target);
    end
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (rb[i] && n < LIM) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rb[i] !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle[%0d] report_busy still %b", i, rb[i]);
    end
  endtask

  task automatic test_reset;
    #12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ustart[i], udata[i], rb[i], ov[i]} !== 11'd0) begin
        errors++;
        $display("FAIL reset[%0d] start=%b data=%h busy=%b ovr=%b want all 0",
                 i, ustart[i], udata[i], rb[i], ov[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    string exp = {hdr, "072\r\n"};
    int base = rx_n[0];
    send(0, 8'd72);
    wait_bytes(0, base + exp.len());
    wait_idle(0);
    repeat (3) @(negedge clk);
    checks++;
    if (rx_n[0] - base !== exp.len()) begin
      errors++;
      $display("FAIL basic_starts got %0d want %0d", rx_n[0] - base, exp.len());
    end
    for (int k = 0; k < exp.len(); k++) begin
      checks++;
      if (rx_buf[0][base+k] !== exp[k]) begin
        errors++;
        $display("FAIL basic_byte%0d got %h want %h", k, rx_buf[0][base+k], exp[k]);
      end
    end
    checks++;
    if (rb[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle report_busy got %b want 0", rb[0]);
    end
  endtask

  task automatic test_extremes;
    logic [7:0] vals [2] = '{8'd0, 8'd255};
    int         clen [2] = '{1, 8};
    string      exps [2];
    string      exp1;
    int base, n;
    exps[0] = {hdr, "000\r\n"};
    exps[1] = {hdr, "255\r\n"};
    for (int t = 0; t < 2; t++) begin
      base = rx_n[0];
      send(0, vals[t]);
      n = 0;
      while (ustart[0] === 1'b0 && n < 50) begin
        n++;
        @(negedge clk);
      end
`ifndef BPM_HDR_EN
      checks++;
      if (n !== clen[t]) begin
        errors++;
        $display("FAIL conv_len_%0d got %0d want %0d", vals[t], n, clen[t]);
      end
`endif
      wait_bytes(0, base + exps[t].len());
      wait_idle(0);
      for (int k = 0; k < exps[t].len(); k++) begin
        checks++;
        if (rx_buf[0][base+k] !== exps[t][k]) begin
          errors++;
          $display("FAIL ext_%0d_byte%0d got %h want %h", vals[t], k,
                   rx_buf[0][base+k], exps[t][k]);
        end
      end
    end
    exp1 = {hdr, "005\n"};
    base = rx_n[1];
    send(1, 8'd5);
    wait_bytes(1, base + exp1.len());
    wait_idle(1);
    repeat (2) @(negedge clk);
    checks++;
    if (rx_n[1] - base !== exp1.len()) begin
      errors++;
      $display("FAIL lf_count got %0d want %0d", rx_n[1] - base, exp1.len());
    end
    for (int k = 0; k < exp1.len(); k++) begin
      checks++;
      if (rx_buf[1][base+k] !== exp1[k]) begin
        errors++;
        $display("FAIL lf_byte%0d got %h want %h", k, rx_buf[1][base+k], exp1[k]);
      end
    end
  endtask

  task automatic test_overrun;
    string exp = {hdr, "100\r\n", hdr, "061\r\n"};
    int base = rx_n[0];
    send(0, 8'd100);
    wait_bytes(0, base + 1);
    checks++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovr_pre got %b want 0", ov[0]);
    end
    send(0, 8'd60);
    send(0, 8'd61);
    checks++;
    if (ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set got %b want 1", ov[0]);
    end
    wait_bytes(0, base + exp.len());
    wait_idle(0);
    repeat (3) @(negedge clk);
    checks++;
    if (rx_n[0] - base !== exp.len()) begin
      errors++;
      $display("FAIL ovr_count got %0d want %0d", rx_n[0] - base, exp.len());
    end
    for (int k = 0; k < exp.len(); k++) begin
      checks++;
      if (rx_buf[0][base+k] !== exp[k]) begin
        errors++;
        $display("FAIL ovr_byte%0d got %h want %h", k, rx_buf[0][base+k], exp[k]);
      end
    end
    checks++;
    if (ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky got %b want 1", ov[0]);
    end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got %b want 0", ov[0]);
    end
  endtask

  task automatic test_idle_entry;
    string exp = {hdr, "044\r\n", hdr, "090\r\n"};
    int base = rx_n[0];
    int n = 0;
    send(0, 8'd44);
    wait_bytes(0, base + hdr.len() + 5);
    while (ubusy[0] === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    // busy just fell: the FSM enters IDLE on the coming edge
    bv[0]   = 1'b1;
    bval[0] = 8'd90;
    @(negedge clk);
    bv[0]   = 1'b0;
    checks++;
    if (rb[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_entry_busy got %b want 0", rb[0]);
    end
    @(negedge clk);
    checks++;
    if (rb[0] !== 1'b1) begin
      errors++;
      $display("FAIL idle_pending_served got %b want 1", rb[0]);
    end
    wait_bytes(0, base + exp.len());
    wait_idle(0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < exp.len(); k++) begin
      checks++;
      if (rx_buf[0][base+k] !== exp[k]) begin
        errors++;
        $display("FAIL idle_byte%0d got %h want %h", k, rx_buf[0][base+k], exp[k]);
      end
    end
    checks++;
    if (ov[0] !== 1'b0 || rx_n[0] - base !== exp.len()) begin
      errors++;
      $display("FAIL idle_ovr_count ovr=%b n=%0d want 0 %0d", ov[0], rx_n[0] - base, exp.len());
    end
  endtask

  task automatic test_mid_reset;
    string exp = {hdr, "033\r\n"};
    int base = rx_n[0];
    send(0, 8'd47);
    wait_bytes(0, base + hdr.len() + 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ustart[0] !== 1'b0 || rb[0] !== 1'b0 || udata[0] !== 8'h00) begin
      errors++;
      $display("FAIL midreset start=%b busy=%b data=%h want 0 0 00",
               ustart[0], rb[0], udata[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (BYTE_CYC + 2) @(negedge clk);
    base = rx_n[0];
    send(0, 8'd33);
    wait_bytes(0, base + exp.len());
    wait_idle(0);
    repeat (3) @(negedge clk);
    checks++;
    if (rx_n[0] - base !== exp.len()) begin
      errors++;
      $display("FAIL post_reset_count got %0d want %0d", rx_n[0] - base, exp.len());
    end
    for (int k = 0; k < exp.len(); k++) begin
      checks++;
      if (rx_buf[0][base+k] !== exp[k]) begin
        errors++;
        $display("FAIL post_reset_byte%0d got %h want %h", k, rx_buf[0][base+k], exp[k]);
      end
    end
  endtask

  task automatic test_gap;
    string exp = {hdr, "120\r\n"};
    int base = rx_n[2];
    int n = 0;
    send(2, 8'd120);
    wait_bytes(2, base + exp.len());
    while (ubusy[2] === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    @(negedge clk);
    while (rb[2] === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL gap_cycles got %0d want 4", n);
    end
    for (int k = 0; k < exp.len(); k++) begin
      checks++;
      if (rx_buf[2][base+k] !== exp[k]) begin
        errors++;
        $display("FAIL gap_byte%0d got %h want %h", k, rx_buf[2][base+k], exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_overrun();
    test_idle_entry();
    test_mid_reset();
    test_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
